// File: rtl/multi_edge_detector.sv
// Multi-channel edge detector: per-channel synchroniser, stable-count glitch
// filter, runtime edge-mode select, one-cycle pulse, edge type and sticky flag.
module multi_edge_detector #(
    parameter int unsigned N_CH        = 4,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DEBOUNCE    = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N_CH-1:0]     din,
    input  logic [2*N_CH-1:0]   mode,
    input  logic [N_CH-1:0]     clr,
    output logic [N_CH-1:0]     level,
    output logic [N_CH-1:0]     pulse,
    output logic [N_CH-1:0]     edge_type,
    output logic [N_CH-1:0]     sticky,
    output logic                any_pulse
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);

    logic [N_CH-1:0] w_level;
    logic [N_CH-1:0] w_rise;
    logic [N_CH-1:0] w_fall;
    logic [N_CH-1:0] w_qual;

    logic [N_CH-1:0] r_level_d;
    logic [N_CH-1:0] r_pulse;
    logic [N_CH-1:0] r_edge_type;
    logic [N_CH-1:0] r_sticky;
    logic            r_any_pulse;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        logic [SYNC_STAGES-1:0] r_sync;
        logic [CNT_W-1:0]       r_cnt;
        logic                   r_level;
        logic                   w_s;

        assign w_s = r_sync[SYNC_STAGES-1];

        // Level only follows the synchronised input after DEBOUNCE consecutive mismatches
        always_ff @(posedge clk) begin
            if (!reset) begin
                r_sync  <= '0;
                r_cnt   <= '0;
                r_level <= 1'b0;
            end else begin
                r_sync <= {r_sync[SYNC_STAGES-2:0], din[g]};
                if (w_s == r_level) begin
                    r_cnt <= '0;
                end else if (r_cnt == CNT_LAST) begin
                    r_level <= w_s;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end
        end

        assign w_level[g] = r_level;
        assign w_qual[g]  = (w_rise[g] & mode[2*g]) | (w_fall[g] & mode[2*g+1]);
    end

    assign w_rise = w_level & ~r_level_d;
    assign w_fall = ~w_level & r_level_d;

    // Pulse lands one cycle after the level change; sticky sets from the pulse itself
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_level_d   <= '0;
            r_pulse     <= '0;
            r_edge_type <= '0;
            r_sticky    <= '0;
            r_any_pulse <= 1'b0;
        end else begin
            r_level_d   <= w_level;
            r_pulse     <= w_qual;
            r_edge_type <= (w_qual & w_rise) | (~w_qual & r_edge_type);
            r_sticky    <= r_pulse | (r_sticky & ~clr);
            r_any_pulse <= |w_qual;
        end
    end

    assign level     = w_level;
    assign pulse     = r_pulse;
    assign edge_type = r_edge_type;
    assign sticky    = r_sticky;
    assign any_pulse = r_any_pulse;

endmodule

// File: tb/tb_multi_edge_detector.sv
// Randomised bench for multi_edge_detector against a history-based reference model.
module tb_multi_edge_detector;

    localparam int unsigned N_CH        = 4;
    localparam int unsigned SYNC_STAGES = 2;
    localparam int unsigned DEBOUNCE    = 4;
    localparam int          NCYC        = 4000;
    localparam int          S           = int'(SYNC_STAGES);
    localparam int          D           = int'(DEBOUNCE);

    logic                clk = 1'b0;
    logic                reset;
    logic [N_CH-1:0]     din;
    logic [2*N_CH-1:0]   mode;
    logic [N_CH-1:0]     clr;
    logic [N_CH-1:0]     level;
    logic [N_CH-1:0]     pulse;
    logic [N_CH-1:0]     edge_type;
    logic [N_CH-1:0]     sticky;
    logic                any_pulse;

    always #5 clk = ~clk;

    multi_edge_detector #(
        .N_CH        (N_CH),
        .SYNC_STAGES (SYNC_STAGES),
        .DEBOUNCE    (DEBOUNCE)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .din       (din),
        .mode      (mode),
        .clr       (clr),
        .level     (level),
        .pulse     (pulse),
        .edge_type (edge_type),
        .sticky    (sticky),
        .any_pulse (any_pulse)
    );

    int n_vec = 0;
    int n_err = 0;
    int t_now = 0;

    // Reference state: din sampled at every edge, plus what the outputs should be
    bit [N_CH-1:0] din_h [NCYC];
    bit [N_CH-1:0] m_level, m_pulse, m_etype, m_sticky;
    bit            m_any;
    int            anchor  [N_CH];
    int            flip_at [N_CH];
    int            last_rst;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s @cycle %0d: got %0h want %0h", tag, t_now, obs, exp);
        end
    endtask

    // Value the synchroniser presents just before edge j
    function automatic bit samp(input int ch, input int j);
        if (j - S > last_rst) return din_h[j - S][ch];
        return 1'b0;
    endfunction

    task automatic model_edge(input int t, input bit rst_n, input bit [2*N_CH-1:0] md,
                              input bit [N_CH-1:0] cl);
        bit [N_CH-1:0] np;
        bit            ok;
        if (!rst_n) begin
            m_level  = '0;
            m_pulse  = '0;
            m_etype  = '0;
            m_sticky = '0;
            m_any    = 1'b0;
            last_rst = t;
            for (int ch = 0; ch < int'(N_CH); ch++) begin
                anchor[ch]  = t;
                flip_at[ch] = -100;
            end
        end else begin
            np = '0;
            for (int ch = 0; ch < int'(N_CH); ch++) begin
                if (flip_at[ch] == t - 1)
                    np[ch] = m_level[ch] ? md[2*ch] : md[2*ch+1];
                if (np[ch]) m_etype[ch] = m_level[ch];
            end
            m_sticky = m_pulse | (m_sticky & ~cl);
            for (int ch = 0; ch < int'(N_CH); ch++) begin
                ok = 1'b1;
                for (int k = 0; k < D; k++) begin
                    if ((t - k) <= anchor[ch] || samp(ch, t - k) == m_level[ch]) ok = 1'b0;
                end
                if (ok) begin
                    m_level[ch] = ~m_level[ch];
                    anchor[ch]  = t;
                    flip_at[ch] = t;
                end
            end
            m_pulse = np;
            m_any   = |np;
        end
    endtask

    initial begin
        bit [N_CH-1:0] nd;
        reset = 1'b0;
        din   = '0;
        mode  = '0;
        clr   = '0;
        last_rst = 0;
        for (int ch = 0; ch < int'(N_CH); ch++) begin
            anchor[ch]  = 0;
            flip_at[ch] = -100;
        end

        for (int t = 0; t < NCYC; t++) begin
            @(negedge clk);
            t_now = t;
            reset = (t < 2) ? 1'b0 : ($urandom_range(0, 499) != 0);
            nd = din;
            if (t >= 2000 && t < 3000) begin
                // all channels toggle together, every edge type enabled
                mode = '1;
                nd   = (((t - 2000) / 12) % 2 == 1) ? '1 : '0;
            end else begin
                for (int ch = 0; ch < int'(N_CH); ch++) begin
                    if (t < 2000) begin
                        if ($urandom_range(0, 7) == 0) nd[ch] = ~nd[ch];
                    end else begin
                        if ($urandom_range(0, 2) == 0) nd[ch] = ~nd[ch];
                    end
                    if ($urandom_range(0, 39) == 0) mode[2*ch +: 2] = 2'($urandom_range(0, 3));
                end
            end
            din = nd;
            clr = N_CH'($urandom & $urandom & $urandom);
            din_h[t] = din;

            @(posedge clk);
            model_edge(t, reset, mode, clr);
            #1;
            check_eq("level",     32'(level),     32'(m_level));
            check_eq("pulse",     32'(pulse),     32'(m_pulse));
            check_eq("edge_type", 32'(edge_type), 32'(m_etype));
            check_eq("sticky",    32'(sticky),    32'(m_sticky));
            check_eq("any_pulse", 32'(any_pulse), 32'(m_any));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
